// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers: ID/EX payload layout and the
// occupancy state encoding of a skid-buffered stage.
package pipe_pkg;

  localparam int IDEX_W = 106;

  // ID/EX bundle as carried between decode and execute.
  typedef struct packed {
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic [4:0]  rd;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] imm;
  } idex_payload_t;

  // Encoding equals the number of held payloads, so it doubles as occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload register with load and clear; clear wins over load.
module pipe_slot #(
  parameter int DATA_W = 106
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Payload storage: reset and clear zero it, load captures d.
  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with flush and a
// saturating count of payloads killed by flush. in_ready depends only on
// registered state, so there is no combinational path from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = IDEX_W,
  parameter int ZERO_BUBBLE = 1,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic             ZB      = (ZERO_BUBBLE != 0);

  occ_state_t        state, state_nxt;
  logic              accept, emit;
  logic              main_load, main_clr, skid_load, skid_clr;
  logic [DATA_W-1:0] main_d, main_q, skid_q;
  logic [1:0]        drop_add;
  logic [CNT_W+1:0]  drop_sum;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  // Main slot already clears on entry to EMPTY; the mask keeps the bubble
  // guarantee explicit at the port.
  assign out_data  = (ZB && !out_valid) ? '0 : main_q;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next state and slot steering from accept/emit/flush.
  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_d    = in_data;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      // Everything held or arriving is killed; an emit this cycle still
      // left the stage and is excluded from the drop count below.
      state_nxt = EMPTY;
      main_clr  = ZB;
      skid_clr  = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            skid_load = 1'b1;
          end else if (emit) begin
            state_nxt = EMPTY;
            main_clr  = ZB;
          end
        end
        FULL: begin
          // in_ready is low here, so the only move is skid -> main.
          if (emit) begin
            state_nxt = ONE;
            main_load = 1'b1;
            main_d    = skid_q;
            skid_clr  = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Payloads lost to a flush: held ones not emitted plus the one accepted.
  assign drop_add = occupancy - {1'b0, emit} + {1'b0, accept};
  assign drop_sum = {2'b00, drop_cnt} + {{CNT_W{1'b0}}, drop_add};

  // Saturating flush-drop counter; reset clears it without counting.
  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (flush)
      drop_cnt <= (drop_sum[CNT_W+1:CNT_W] != 2'b00) ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;

  localparam int DATA_W = 106;
  localparam int CNT_W  = 8;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, in_valid, out_ready, flush;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  drop_cnt;

  int                n_chk = 0;
  int                n_pass = 0;
  bit                chk_en = 0;
  logic [DATA_W-1:0] q[$];
  int                mdrop = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .ZERO_BUBBLE(1), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One clock: drive inputs, compare outputs with the model, advance model.
  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [DATA_W-1:0] d, input logic o);
    int n;
    bit acc, emt;
    logic [DATA_W-1:0] exp_d;
    rst = r; flush = f; in_valid = v; in_data = d; out_ready = o;
    #1;
    n = q.size();
    exp_d = (n > 0) ? q[0] : '0;
    if (chk_en) begin
      chk("out_valid", out_valid, n > 0);
      chk("out_data",  out_data,  exp_d);
      chk("in_ready",  in_ready,  n < 2);
      chk("occupancy", occupancy, n);
      chk("drop_cnt",  drop_cnt,  mdrop);
    end
    acc = v && (n < 2);
    emt = (n > 0) && o;
    @(posedge clk);
    if (r) begin
      q.delete();
      mdrop = 0;
      chk_en = 1;
    end else begin
      if (emt) void'(q.pop_front());
      if (f) begin
        mdrop = mdrop + (n - int'(emt)) + int'(acc);
        if (mdrop > MAXC) mdrop = MAXC;
        q.delete();
      end else if (acc) begin
        q.push_back(d);
      end
    end
    @(negedge clk);
  endtask

  task automatic fill_full();
    cyc(0, 0, 1, DATA_W'($urandom), 0);
    cyc(0, 0, 1, DATA_W'($urandom), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    cyc(1, 0, 0, '0, 0);
    cyc(1, 0, 0, '0, 0);

    // first payload visible one cycle after acceptance
    cyc(0, 0, 1, 106'h0AA, 1);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_data",  out_data,  106'h0AA);
    chk("lat_occ",   occupancy, 2'd1);

    // back-to-back stream, full throughput
    for (int i = 1; i <= 16; i++) cyc(0, 0, 1, DATA_W'(i), 1);
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);

    // stall fills both slots, then drains in order
    cyc(0, 0, 1, 106'h111, 0);
    cyc(0, 0, 1, 106'h222, 0);
    chk("stall_occ",   occupancy, 2'd2);
    chk("stall_rdy",   in_ready,  1'b0);
    chk("stall_data",  out_data,  106'h111);
    cyc(0, 0, 0, '0, 1);
    chk("drain_data2", out_data,  106'h222);
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);

    // flush while full with in_valid high
    fill_full();
    cyc(0, 1, 1, 106'h333, 1'b0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_data",  out_data,  '0);
    chk("flush_rdy",   in_ready,  1'b1);
    chk("flush_drop",  drop_cnt,  8'd2);

    // saturate the drop counter
    while (mdrop < 254) begin
      fill_full();
      cyc(0, 1, 0, '0, 0);
    end
    chk("pre_sat", drop_cnt, 8'd254);
    fill_full();
    cyc(0, 1, 0, '0, 0);
    chk("sat_255", drop_cnt, 8'd255);
    cyc(0, 1, 1, 106'h1, 0);
    fill_full();
    cyc(0, 1, 0, '0, 0);
    chk("sat_hold", drop_cnt, 8'd255);

    // reset beats flush while full
    fill_full();
    cyc(1, 1, 1, 106'h5, 0);
    chk("rst_occ",  occupancy, 2'd0);
    chk("rst_drop", drop_cnt,  8'd0);
    chk("rst_data", out_data,  '0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 7), rd, ($urandom_range(0, 9) < 6));
    end
    cyc(0, 0, 0, '0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, 106, payload width in bits (default = ID/EX bundle: 32+32+5+4+1+32).
REQ-002 Parameter: ZERO_BUBBLE, 1, when 1 out_data SHALL read all-zero whenever out_valid=0.
REQ-003 Parameter: CNT_W, 8, width of the saturating flush-drop counter.
REQ-004 Port: clk  input  1  sole clock, all state updates on posedge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_valid  input  1  upstream stage presents a payload.
REQ-007 Port: in_data  input  DATA_W  upstream payload.
REQ-008 Port: in_ready  output  1  stage accepts a payload this cycle; driven from register state only, no combinational path from out_ready.
REQ-009 Port: out_valid  output  1  stage holds a payload for downstream.
REQ-010 Port: out_data  output  DATA_W  oldest held payload.
REQ-011 Port: out_ready  input  1  downstream accepts; out_ready=0 is a stall.
REQ-012 Port: flush  input  1  discard all held and incoming payloads (branch/exception kill).
REQ-013 Port: occupancy  output  2  number of held payloads, 0..2.
REQ-014 Port: drop_cnt  output  CNT_W  saturating count of valid payloads discarded by flush.

Function
REQ-015 Accept = in_valid & in_ready; emit = out_valid & out_ready; a payload SHALL be accepted or emitted only on these conditions.
REQ-016 Storage: main slot (drives out_data) plus one skid slot; states EMPTY (0), ONE (main), FULL (main+skid).
REQ-017 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-018 ONE: accept & emit -> ONE with main = new payload; accept only -> FULL (new payload in skid); emit only -> EMPTY; neither -> ONE, main held.
REQ-019 FULL: emit -> ONE with main = skid; no emit -> FULL, both held; in_ready=0 so no accept possible.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL.
REQ-021 out_valid SHALL be 1 in ONE and FULL; latency from accept in EMPTY to out_valid = 1 cycle.
REQ-022 Payloads SHALL leave in acceptance order; none duplicated or lost except by flush.
REQ-023 Sustained throughput SHALL be one payload per cycle while out_ready=1.
REQ-024 flush=1: next state EMPTY regardless of accept/emit; an input accepted in the flush cycle is discarded; an emit in the flush cycle still counts as delivered.
REQ-025 drop_cnt SHALL add (held payloads not emitted this cycle + accepted payload) on each flush cycle, saturating at 2^CNT_W-1, never wrapping.
REQ-026 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 With ZERO_BUBBLE=1, main slot SHALL clear to zero on entry to EMPTY; with 0, it SHALL hold its last value.

Reset
REQ-028 reset=1 at posedge SHALL force: state EMPTY, out_valid=0, out_data=0, occupancy=0, drop_cnt=0, skid slot=0; in_ready=1 from the first cycle after reset.
REQ-029 reset SHALL take priority over flush, in_valid and out_ready; payloads held mid-operation are dropped without incrementing drop_cnt.

Structure
REQ-030 Shared package pipe_pkg SHALL hold: IDEX_W constant (106), idex_payload_t packed struct (data_1, data_2, rd, alu_ctrl, alu_src, imm), occupancy state enum (EMPTY, ONE, FULL).
REQ-031 One sub-module pipe_slot (DATA_W register with load, clear, synchronous reset) SHALL be instantiated twice for main and skid slots.

Verification
REQ-032 Reset then in_valid=1, in_data=0x0AA, out_ready=1 -> next cycle out_valid=1, out_data=0x0AA, occupancy=1.
REQ-033 Stream 0x001..0x010 with out_ready=1 -> 16 outputs in order, one per cycle, in_ready constantly 1.
REQ-034 out_ready=0, push 0x111 then 0x222 -> occupancy=2, in_ready=0, out_data=0x111 held; out_ready=1 -> 0x111 then 0x222 emitted on consecutive cycles.
REQ-035 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=1, drop_cnt=2 (skid+main; in_ready=0 so no accept).
REQ-036 drop_cnt preloaded to 254 by repeated flushes, flush in FULL -> drop_cnt=255; further flushes -> stays 255.
REQ-037 reset asserted while FULL with flush=1 -> next cycle occupancy=0, drop_cnt=0, out_data=0.
